// File: rtl/warriorjacq9_pkg.sv
// Shared types and constants for the warriorjacq9 4-bit accumulator-style CPU slice.
package warriorjacq9_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_REQ_OPND,
    ST_REQ_REG,
    ST_EXEC,
    ST_WB
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_SUBI = 4'b0010;
  localparam logic [3:0] OP_ANDI = 4'b0011;
  localparam logic [3:0] OP_ORI  = 4'b0100;
  localparam logic [3:0] OP_XORI = 4'b0101;

  localparam logic [3:0] BUS_IDLE      = 4'b0000;
  localparam logic [3:0] BUS_NEXT_OPND = 4'b0011;
  localparam logic [3:0] BUS_READ_REG  = 4'b0001;

  // Bit positions of the flags within uo_out
  localparam int FLAG_C = 4;
  localparam int FLAG_Z = 5;

  localparam logic [7:0] OE_DRIVE = 8'h0F;
  localparam logic [7:0] OE_READ  = 8'h00;

endpackage

// File: rtl/warriorjacq9_alu.sv
// Combinational 4-bit ALU; valid_o is low for opcodes that must leave state untouched.
module warriorjacq9_alu
  import warriorjacq9_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] result_o,
  output logic       carry_o,
  output logic       zero_o,
  output logic       valid_o
);

  logic [4:0] sum;
  logic [4:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  // Bit 4 of the 5-bit difference is set exactly when b_i > a_i
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = 4'h0;
    carry_o  = 1'b0;
    valid_o  = 1'b1;
    case (opcode_i)
      OP_ADDI: begin result_o = sum[3:0];  carry_o = sum[4];  end
      OP_SUBI: begin result_o = diff[3:0]; carry_o = diff[4]; end
      OP_ANDI: result_o = a_i & b_i;
      OP_ORI:  result_o = a_i | b_i;
      OP_XORI: result_o = a_i ^ b_i;
      default: valid_o = 1'b0;
    endcase
  end

  assign zero_o = (result_o == 4'h0);

endmodule

// File: rtl/tt_um_warriorjacq9.sv
// Five-cycle fetch / operand / register-read / execute / write-back controller
// around warriorjacq9_alu, talking to an external register block over uio.
module tt_um_warriorjacq9
  import warriorjacq9_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e     state_q, state_d;
  logic [3:0] opcode_q, imm_q, regidx_q, regval_q;
  logic [3:0] tmp_q, result_q;
  logic       tmp_c_q, tmp_z_q, tmp_v_q;
  logic       carry_q, zero_q;

  logic [3:0] alu_res;
  logic       alu_c, alu_z, alu_v;
  logic [3:0] bus_code;

  warriorjacq9_alu u_alu (
    .opcode_i (opcode_q),
    .a_i      (regval_q),
    .b_i      (imm_q),
    .result_o (alu_res),
    .carry_o  (alu_c),
    .zero_o   (alu_z),
    .valid_o  (alu_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = ST_FETCH;
    bus_code = BUS_IDLE;
    uio_oe   = OE_DRIVE;
    case (state_q)
      ST_FETCH:    state_d = ST_REQ_OPND;
      ST_REQ_OPND: begin state_d = ST_REQ_REG; bus_code = BUS_NEXT_OPND; end
      ST_REQ_REG:  begin state_d = ST_EXEC; bus_code = BUS_READ_REG; uio_oe = OE_READ; end
      ST_EXEC:     state_d = ST_WB;
      ST_WB:       state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= 4'h0;
      imm_q    <= 4'h0;
      regidx_q <= 4'h0;
      regval_q <= 4'h0;
      tmp_q    <= 4'h0;
      tmp_c_q  <= 1'b0;
      tmp_z_q  <= 1'b0;
      tmp_v_q  <= 1'b0;
      result_q <= 4'h0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          opcode_q <= ui_in[3:0];
          imm_q    <= ui_in[7:4];
        end
        ST_REQ_OPND: regidx_q <= ui_in[7:4];
        ST_REQ_REG:  regval_q <= uio_in[3:0];
        ST_EXEC: begin
          tmp_q   <= alu_res;
          tmp_c_q <= alu_c;
          tmp_z_q <= alu_z;
          tmp_v_q <= alu_v;
        end
        ST_WB: if (tmp_v_q) begin
          result_q <= tmp_q;
          carry_q  <= tmp_c_q;
          zero_q   <= tmp_z_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    uo_out         = 8'h00;
    uo_out[3:0]    = bus_code;
    uo_out[FLAG_C] = carry_q;
    uo_out[FLAG_Z] = zero_q;
  end

  assign uio_out = {4'h0, result_q};

  // regidx is a debug-only latch; ena and the upper uio_in bits are don't-cares
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4], regidx_q};

endmodule

// File: tb/tb_tt_um_warriorjacq9.sv
// Self-checking bench: hand-computed vector table, random instructions against an
// arithmetic reference model, and a reset-during-EXEC sequence.
module tb_tt_um_warriorjacq9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_res;
  logic       m_c, m_z;

  typedef struct {
    logic [3:0] op, imm, rv;
    logic [3:0] res;
    logic       c, z;
  } vec_t;

  vec_t tbl[12];

  tt_um_warriorjacq9 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural effect of one instruction, from the ALU rules
  task automatic model(input logic [3:0] op, input logic [3:0] imm, input logic [3:0] rv);
    int s;
    case (op)
      4'd1: begin s = int'(rv) + int'(imm); m_c = (s > 15); m_res = 4'(s % 16); end
      4'd2: begin s = int'(rv) - int'(imm); m_c = (imm > rv); m_res = 4'((s + 16) % 16); end
      4'd3: begin m_res = rv & imm; m_c = 1'b0; end
      4'd4: begin m_res = rv | imm; m_c = 1'b0; end
      4'd5: begin m_res = rv ^ imm; m_c = 1'b0; end
      default: return;
    endcase
    m_z = (m_res == 4'h0);
  endtask

  // Called at a negedge while the DUT is in FETCH; returns at the negedge after the 5th edge.
  // noise=1 scrambles every input that must be ignored in the current state.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] imm, input logic [3:0] rv,
                           input logic noise);
    logic [3:0] exp_code;
    for (int cyc = 0; cyc < 5; cyc++) begin
      exp_code = (cyc == 1) ? 4'b0011 : (cyc == 2) ? 4'b0001 : 4'b0000;
      chk("bus_code", {4'h0, uo_out[3:0]}, {4'h0, exp_code});
      chk("uio_oe", uio_oe, (uo_out[3:0] == 4'b0001) ? 8'h00 : 8'h0F);
      case (cyc)
        0: begin
          ui_in  = {imm, op};
          uio_in = noise ? 8'($urandom) : 8'h00;
        end
        1: ui_in = noise ? 8'($urandom) : {4'd1, op};
        2: begin
          uio_in = noise ? {4'($urandom), rv} : {4'h0, rv};
          if (noise) ui_in = 8'($urandom);
        end
        default: if (noise) begin
          ui_in  = 8'($urandom);
          uio_in = 8'($urandom);
        end
      endcase
      @(negedge clk);
    end
  endtask

  task automatic chk_arch(input string tag, input logic [3:0] res, input logic c, input logic z);
    chk({tag, "_result"}, uio_out, {4'h0, res});
    chk({tag, "_flags"}, {4'h0, uo_out[7:4]}, {6'h00, z, c});
  endtask

  initial begin
    logic [3:0] op, imm, rv;

    tbl[0]  = '{4'd1, 4'd2, 4'd4, 4'h6, 1'b0, 1'b0};  // ADDI 2, first instruction
    tbl[1]  = '{4'd1, 4'd3, 4'd4, 4'h7, 1'b0, 1'b0};  // ADDI 3
    tbl[2]  = '{4'd1, 4'd1, 4'hF, 4'h0, 1'b1, 1'b1};  // wrap to zero
    tbl[3]  = '{4'd2, 4'd3, 4'd2, 4'hF, 1'b1, 1'b0};  // SUBI borrow
    tbl[4]  = '{4'd0, 4'd5, 4'd3, 4'hF, 1'b1, 1'b0};  // NOP keeps state
    tbl[5]  = '{4'hA, 4'd7, 4'd9, 4'hF, 1'b1, 1'b0};  // undefined op keeps state
    tbl[6]  = '{4'd3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0};  // ANDI
    tbl[7]  = '{4'd4, 4'd5, 4'hA, 4'hF, 1'b0, 1'b0};  // ORI
    tbl[8]  = '{4'd5, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1};  // XORI to zero
    tbl[9]  = '{4'd2, 4'd5, 4'd5, 4'h0, 1'b0, 1'b1};  // SUBI equal
    tbl[10] = '{4'd2, 4'd1, 4'd0, 4'hF, 1'b1, 1'b0};  // 0 - 1
    tbl[11] = '{4'd1, 4'hF, 4'hF, 4'hE, 1'b1, 1'b0};  // F + F

    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #12;
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h0F);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].op, tbl[i].imm, tbl[i].rv, 1'b0);
      chk_arch($sformatf("vec%0d", i), tbl[i].res, tbl[i].c, tbl[i].z);
    end
    m_res = tbl[11].res;
    m_c   = tbl[11].c;
    m_z   = tbl[11].z;

    for (int i = 0; i < 60; i++) begin
      op  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 5));
      imm = 4'($urandom);
      rv  = 4'($urandom);
      run_instr(op, imm, rv, 1'b1);
      model(op, imm, rv);
      chk_arch($sformatf("rnd%0d_op%0h", i, op), m_res, m_c, m_z);
    end

    // Abort an ADDI 7 in EXEC; nothing may be written back
    ui_in = {4'd7, 4'd1};
    @(negedge clk);
    ui_in = {4'd1, 4'd1};
    @(negedge clk);
    uio_in = 8'h04;
    @(negedge clk);
    chk("exec_code", {4'h0, uo_out[3:0]}, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("midrst_uo_out", uo_out, 8'h00);
    chk("midrst_uio_out", uio_out, 8'h00);
    chk("midrst_uio_oe", uio_oe, 8'h0F);
    @(negedge clk);
    chk("midrst_hold_uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    run_instr(4'd1, 4'd2, 4'd4, 1'b0);
    chk_arch("post_rst", 4'h6, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
